seq_divider_4b: RTL and testbench
=================================

// Module: seq_divider_4b
// PURPOSE
// - Multi-cycle unsigned restoring divider for the 4-bit arithmetic datapath: quotient = dividend / divisor, remainder = dividend % divisor.
// - Inverse operation to the existing combinational add/sub path. Each step performs one trial subtraction and decides from its borrow.
// - Sits beside the add/sub block and is driven by the same controller through a start/busy/done handshake.
// PARAMETERS
// - W  4  operand width in bits. Valid range W >= 2. Iteration counter width is clog2(W+1).
// PORTS
// - clk        in   1    rising-edge clock
// - rst        in   1    synchronous, active-high reset
// - start      in   1    request a division; sampled only in IDLE
// - dividend   in   W    unsigned dividend; bit 0 = MSB
// - divisor    in   W    unsigned divisor; bit 0 = MSB
// - busy       out  1    high while in RUN or DONE
// - done       out  1    one-cycle pulse; results valid from this cycle
// - quotient   out  W    unsigned quotient; bit 0 = MSB
// - remainder  out  W    unsigned remainder; bit 0 = MSB
// - dbz        out  1    divide-by-zero flag for the last operation
// BEHAVIOUR
// - Reset, from any state including mid-RUN:
//   - state=IDLE, busy=0, done=0, quotient=0, remainder=0, dbz=0, count=0.
//   - Any in-flight operation is discarded.
// - FSM states: IDLE, RUN, DONE.
// - IDLE & start=1:
//   - Latch Q=dividend, D=divisor, R=0, count=W.
//   - If divisor==0: go straight to DONE with quotient=all-ones, remainder=dividend, dbz=1.
//   - Otherwise: dbz=0, go to RUN.
// - RUN, one step per cycle:
//   - Shift {R,Q} left by 1.
//   - diff = {0,R'} - {0,D}, computed at W+1 bits.
//   - No borrow (diff MSB = 0): R=diff[W-1:0], Q LSB=1. Borrow: R=R', Q LSB=0.
//   - count--. When count reaches 0, go to DONE.
// - DONE: done=1 for exactly one cycle, then IDLE.
// - busy=1 in RUN and DONE, 0 in IDLE.
// - Latency: start sampled at edge t.
//   - Normal case: done=1 during cycle t+W+1.
//   - divisor==0: done=1 during cycle t+1.
// - quotient, remainder and dbz update only when done is asserted. They hold until the next accepted start completes.
// - start while busy=1, including the DONE cycle, is ignored. Operands may change freely while busy.
// - Back-to-back: start asserted in the cycle after done is accepted normally.
// - Boundary cases:
//   - dividend < divisor -> quotient 0, remainder dividend.
//   - divisor=1 -> quotient dividend, remainder 0.
//   - dividend=0 with divisor!=0 -> quotient 0, remainder 0, full W-cycle latency.
// - Invariant when dbz=0: quotient*divisor + remainder == dividend, and remainder < divisor.
// STRUCTURE
// - Shared package arith_pkg:
//   - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
//   - ARITH_W=4.
// - One sub-module, trial_sub:
//   - a W+1-bit combinational subtractor (a + ~b + 1) giving diff and borrow;
//   - reuses the existing full-adder cell chain.
// - Top level: FSM, counter, R/Q/D registers, output registers.
// TESTING
// - Normal divide: rst, then start with 13 / 3 -> busy for 5 cycles; done at t+5; quotient=4, remainder=1, dbz=0.
// - Divide by zero: start with 9 / 0 -> done at t+1; quotient=15, remainder=9, dbz=1; next 6 / 2 gives 3, 0, dbz=0.
// - Boundaries: 15/1 -> 15,0. 5/7 -> 0,5. 0/4 -> 0,0. 15/15 -> 1,0. 8/3 -> 2,2.
// - Ignored start: start 14 / 4, then pulse start with 1 / 1 two cycles later -> result is 3,2; done pulses exactly once.
// - Reset mid-operation: start 12 / 5, rst at t+2 -> all outputs 0 next cycle, state IDLE; a new 12 / 5 completes normally with 2,2.
// - Exhaustive: all 256 operand pairs back-to-back -> invariant holds (or dbz=1 when divisor=0); done exactly once per start; no start lost.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the 4-bit arithmetic datapath (add/sub and divider).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

   localparam int ARITH_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/trial_sub.sv
// Trial subtractor: W+1-bit a - b as a + ~b + 1 on a ripple full-adder chain.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   a, b    in   W   unsigned operands, zero-extended to W+1 bits internally
//   diff    out  W   low W bits of the difference
//   borrow  out  1   MSB of the W+1-bit difference; 1 when a < b
module trial_sub #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);

   logic [W:0] a_ext;
   logic [W:0] b_inv;
   logic [W:0] sum;
   logic [W:0] carry;

   assign a_ext    = {1'b0, a};
   assign b_inv    = ~{1'b0, b};
   // Carry-in of 1 completes the two's complement of b.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i <= W; i++) begin : g_fa
      assign sum[i] = a_ext[i] ^ b_inv[i] ^ carry[i];
      if (i < W) begin : g_carry
         assign carry[i+1] = (a_ext[i] & b_inv[i]) | (a_ext[i] & carry[i]) | (b_inv[i] & carry[i]);
      end
   end

   assign diff   = sum[W-1:0];
   assign borrow = sum[W];

endmodule

// File: rtl/seq_divider_4b.sv
// Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
// Latency: done pulses W+1 cycles after start is sampled (1 cycle when divisor is zero).
// Backpressure: start is only accepted in IDLE; start while busy is dropped, operands latched at start.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request a division (sampled in IDLE only)
//   dividend, divisor    unsigned operands, bit 0 = MSB
//   busy                 high in RUN and DONE
//   done                 one-cycle pulse, results valid from this cycle
//   quotient, remainder  unsigned results, bit 0 = MSB, held until next completion
//   dbz                  divide-by-zero flag for the last completed operation
module seq_divider_4b
   import arith_pkg::*;
#(
   parameter int W = ARITH_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [0:W-1] dividend,
   input  logic [0:W-1] divisor,
   output logic         busy,
   output logic         done,
   output logic [0:W-1] quotient,
   output logic [0:W-1] remainder,
   output logic         dbz
);

   localparam int CW = $clog2(W + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   // Partial remainder only needs W-1 bits between steps: after k < W steps it is
   // bounded by the top k dividend bits. The full W-bit value of the final step
   // goes straight into rem_q.
   logic [W-2:0]  r_q, r_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  d_q, d_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic [W-1:0]  dividend_v;
   logic [W-1:0]  divisor_v;
   logic [W-1:0]  r_shift;
   logic [W-1:0]  diff;
   logic          borrow;
   logic [W-1:0]  step_r;
   logic [W-1:0]  step_q;

   assign dividend_v = dividend;
   assign divisor_v  = divisor;

   // Left shift of {R,Q}: the MSB of Q moves into the LSB of R.
   assign r_shift = {r_q, q_q[W-1]};

   trial_sub #(.W(W)) u_trial_sub (
      .a      (r_shift),
      .b      (d_q),
      .diff   (diff),
      .borrow (borrow)
   );

   // Restore on borrow: keep the shifted remainder, quotient bit is 0.
   assign step_r = borrow ? r_shift : diff;
   assign step_q = {q_q[W-2:0], ~borrow};

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               q_d     = dividend_v;
               d_d     = divisor_v;
               r_d     = '0;
               count_d = CW'(W);
               if (divisor_v == '0) begin
                  quot_d  = '1;
                  rem_d   = dividend_v;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            r_d     = step_r[W-2:0];
            q_d     = step_q;
            count_d = count_q - 1'b1;
            if (count_q == CW'(1)) begin
               quot_d  = step_q;
               rem_d   = step_r;
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider_4b.sv
// Directed bench for seq_divider_4b: latency, results, handshake, reset and all operand pairs.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_divider_4b;

   logic       clk;
   logic       rst;
   logic       start;
   logic [0:3] dividend;
   logic [0:3] divisor;
   logic       busy;
   logic       done;
   logic [0:3] quotient;
   logic [0:3] remainder;
   logic       dbz;

   int n_chk  = 0;
   int n_fail = 0;

   seq_divider_4b dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge. Issues one start, waits for done (bounded),
   // checks latency, busy length, results, and that done is a single pulse.
   task automatic run_div(input string tag, input int a, input int b,
                          input int eq, input int er, input int ed, input int elat);
      int cyc;
      int bcnt;
      dividend = 4'(a);
      divisor  = 4'(b);
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      // Operands must be latched at start; disturb them while busy.
      dividend = ~dividend;
      divisor  = ~divisor;
      cyc  = 1;
      bcnt = 0;
      while (!done && cyc < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         cyc++;
      end
      if (busy) bcnt++;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " latency"}, 32'(cyc), 32'(elat));
      chk({tag, " busy_cycles"}, 32'(bcnt), 32'(elat));
      chk({tag, " quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " remainder"}, 32'(remainder), 32'(er));
      chk({tag, " dbz"}, 32'(dbz), 32'(ed));
      @(negedge clk);
      chk({tag, " done_single"}, 32'(done), 32'd0);
      chk({tag, " idle_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int dcnt;
      int dcyc;
      logic [0:3] rq;
      logic [0:3] rr;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset quotient", 32'(quotient), 32'd0);
      chk("reset remainder", 32'(remainder), 32'd0);
      chk("reset dbz", 32'(dbz), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Normal divide and divide by zero followed by a normal one.
      run_div("13/3", 13, 3, 4, 1, 0, 5);
      run_div("9/0", 9, 0, 15, 9, 1, 1);
      run_div("6/2", 6, 2, 3, 0, 0, 5);

      // Boundaries.
      run_div("15/1", 15, 1, 15, 0, 0, 5);
      run_div("5/7", 5, 7, 0, 5, 0, 5);
      run_div("0/4", 0, 4, 0, 0, 0, 5);
      run_div("15/15", 15, 15, 1, 0, 0, 5);
      run_div("8/3", 8, 3, 2, 2, 0, 5);

      // Start while busy is ignored: 14/4 runs, the 1/1 request two cycles later is dropped.
      dividend = 4'd14;
      divisor  = 4'd4;
      start    = 1'b1;
      dcnt     = 0;
      dcyc     = 0;
      rq       = '0;
      rr       = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            dcyc = c;
            rq   = quotient;
            rr   = remainder;
         end
         start = (c == 2);
         if (c == 2) begin
            dividend = 4'd1;
            divisor  = 4'd1;
         end
      end
      chk("ignored done_count", 32'(dcnt), 32'd1);
      chk("ignored latency", 32'(dcyc), 32'd5);
      chk("ignored quotient", 32'(rq), 32'd3);
      chk("ignored remainder", 32'(rr), 32'd2);
      chk("ignored idle_after", 32'(busy), 32'd0);

      // Reset in the middle of a run clears everything.
      dividend = 4'd12;
      divisor  = 4'd5;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst quotient", 32'(quotient), 32'd0);
      chk("midrst remainder", 32'(remainder), 32'd0);
      chk("midrst dbz", 32'(dbz), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run_div("12/5 after reset", 12, 5, 2, 2, 0, 5);

      // All operand pairs, back-to-back.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0)
               run_div($sformatf("exh %0d/%0d", a, b), a, b, 15, a, 1, 1);
            else
               run_div($sformatf("exh %0d/%0d", a, b), a, b, a / b, a % b, 0, 5);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
